// File: rtl/femto_mem_pkg.sv
// Shared definitions for the unified-memory port: funct3 encodings, arbiter states, access size.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package femto_mem_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } arb_state_t;

    // Access width in bytes; unknown encodings are treated as a word so
    // the alignment/range checks stay conservative.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        logic [2:0] size;
        case (f3)
            F3_LB, F3_LBU: size = 3'd1;
            F3_LH, F3_LHU: size = 3'd2;
            default:       size = 3'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Legality check for one memory access: funct3 encoding, natural alignment, last byte in range.
// Latency: purely combinational.
// Backpressure: none; the caller decides what to do with an illegal access.
module mem_access_check
    import femto_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic        is_fetch,
    output logic        legal
);

    logic        f3_ok;
    logic        aligned;
    logic        in_range;
    logic [2:0]  size;
    logic [32:0] last_byte;

    // Decode the access and test each legality rule independently
    always_comb begin
        f3_ok     = 1'b0;
        aligned   = 1'b0;
        size      = is_fetch ? 3'd4 : f3_size(funct3);
        // 33-bit sum so an access straddling the top of the 32-bit space
        // cannot wrap back into range.
        last_byte = {1'b0, addr} + {30'b0, size} - 33'd1;
        in_range  = (last_byte < 33'(MEM_BYTES));

        if (is_fetch) begin
            f3_ok = 1'b1;
        end else if (we) begin
            f3_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            f3_ok = (funct3 == F3_LB)  || (funct3 == F3_LH)  || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end

        case (size)
            3'd4:    aligned = (addr[1:0] == 2'b00);
            3'd2:    aligned = (addr[0] == 1'b0);
            default: aligned = 1'b1;
        endcase

        legal = f3_ok && aligned && in_range;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and load/store; load/store has fixed priority.
// Latency: legal request accepted in IDLE at cycle N -> ready at N+2; rejected request -> ready at N+1.
// Backpressure: requester holds req until its ready pulse; inputs are only sampled in IDLE.
module mem_port_arbiter
    import femto_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = 4096,
    parameter logic [2:0]  FETCH_FUNCT3 = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_err,
    output logic [31:0] if_instr,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_funct3,
    output logic        ls_ready,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    arb_state_t  state_q, state_d;
    logic        grant_ls_q, grant_ls_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        if_ready_q, if_ready_d;
    logic        if_err_q, if_err_d;
    logic        ls_ready_q, ls_ready_d;
    logic        ls_err_q, ls_err_d;

    // Candidate request as seen in IDLE (load/store wins over fetch)
    logic        sel_req;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [2:0]  sel_f3;
    logic        sel_legal;

    assign sel_req  = ls_req | if_req;
    assign sel_we   = ls_req & ls_we;
    assign sel_addr = ls_req ? ls_addr   : if_addr;
    assign sel_f3   = ls_req ? ls_funct3 : FETCH_FUNCT3;

    mem_access_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .addr     (sel_addr),
        .funct3   (sel_f3),
        .we       (sel_we),
        .is_fetch (~ls_req),
        .legal    (sel_legal)
    );

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d     = state_q;
        grant_ls_d  = grant_ls_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if_ready_d  = 1'b0;
        if_err_d    = 1'b0;
        ls_ready_d  = 1'b0;
        ls_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_req) begin
                    grant_ls_d = ls_req;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = ls_req ? ls_wdata : wdata_q;
                    funct3_d   = sel_f3;
                    if (sel_legal) begin
                        state_d     = ACCESS;
                        mem_read_d  = ~sel_we;
                        mem_write_d = sel_we;
                    end else begin
                        // Rejected accesses answer immediately and never reach memory
                        state_d  = ERR;
                        ls_ready_d = ls_req;
                        ls_err_d   = ls_req;
                        if_ready_d = ~ls_req;
                        if_err_d   = ~ls_req;
                    end
                end
            end
            ACCESS: begin
                state_d    = RESP;
                ls_ready_d = grant_ls_q;
                if_ready_d = ~grant_ls_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_ls_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if_ready_q  <= 1'b0;
            if_err_q    <= 1'b0;
            ls_ready_q  <= 1'b0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_ls_q  <= grant_ls_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            if_ready_q  <= if_ready_d;
            if_err_q    <= if_err_d;
            ls_ready_q  <= ls_ready_d;
            ls_err_q    <= ls_err_d;
        end
    end

    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_funct3 = funct3_q;
    assign if_ready   = if_ready_q;
    assign if_err     = if_err_q;
    assign ls_ready   = ls_ready_q;
    assign ls_err     = ls_err_q;

    // Memory already formats the load result; only expose it during a ready pulse
    assign if_instr   = if_ready_q ? mem_rdata : '0;
    assign ls_rdata   = ls_ready_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready, if_err;
    logic [31:0] if_instr;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [2:0]  ls_funct3 = '0;
    logic        ls_ready, ls_err;
    logic [31:0] ls_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MEM_BYTES(4096), .FETCH_FUNCT3(3'b010)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_err(if_err), .if_instr(if_instr),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_funct3(ls_funct3),
        .ls_ready(ls_ready), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte array, registered formatted read
    logic [7:0] mem [0:4095];
    int rd_pulses = 0;
    int wr_pulses = 0;
    logic both_hi = 1'b0;

    function automatic logic [31:0] mem_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [11:0] a;
        logic [31:0] w;
        a = addr[11:0];
        w = {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [11:0] a;
        a = mem_addr[11:0];
        if (MemRead && MemWrite) both_hi = 1'b1;
        if (MemWrite) begin
            wr_pulses++;
            mem[a] = mem_wdata[7:0];
            if (mem_funct3 != 3'b000) mem[a + 12'd1] = mem_wdata[15:8];
            if (mem_funct3 == 3'b010) begin
                mem[a + 12'd2] = mem_wdata[23:16];
                mem[a + 12'd3] = mem_wdata[31:24];
            end
        end
        if (MemRead) begin
            rd_pulses++;
            mem_rdata <= mem_load(mem_addr, mem_funct3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [11:0] a, input logic [31:0] v);
        mem[a]         = v[7:0];
        mem[a + 12'd1] = v[15:8];
        mem[a + 12'd2] = v[23:16];
        mem[a + 12'd3] = v[31:24];
    endtask

    // Issue one load/store and wait (bounded) for its ready pulse; lat<0 means none or extra pulses
    task automatic run_ls(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, output int lat, output logic err, output logic [31:0] rd);
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_funct3 = f3; ls_wdata = wd;
        lat = -1; err = 1'b0; rd = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (ls_ready) begin
                if (lat == -1) begin
                    lat = k; err = ls_err; rd = ls_rdata;
                end else begin
                    lat = -2;
                end
                ls_req = 1'b0;
            end
        end
        ls_req = 1'b0;
    endtask

    task automatic run_if(input logic [31:0] addr, output int lat, output logic err, output logic [31:0] rd);
        if_req = 1'b1; if_addr = addr;
        lat = -1; err = 1'b0; rd = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (if_ready) begin
                if (lat == -1) begin
                    lat = k; err = if_err; rd = if_instr;
                end else begin
                    lat = -2;
                end
                if_req = 1'b0;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        #2;
        outs = {MemRead, MemWrite, if_ready, if_err, ls_ready, ls_err, mem_funct3, |mem_addr};
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0", outs);
        end
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        outs = {MemRead, MemWrite, if_ready, if_err, ls_ready, ls_err, mem_funct3, |mem_addr};
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b want 0", outs);
        end
    endtask

    task automatic test_fetch();
        put_word(12'h004, 32'h00500093);
        if_req = 1'b1; if_addr = 32'h4;
        tick();
        checks++;
        if ({MemRead, MemWrite, mem_funct3, mem_addr, if_ready} !== {1'b1, 1'b0, 3'b010, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL fetch_access: rd=%b wr=%b f3=%b addr=%h rdy=%b want rd=1 wr=0 f3=010 addr=4 rdy=0",
                     MemRead, MemWrite, mem_funct3, mem_addr, if_ready);
        end
        tick();
        checks++;
        if ({if_ready, if_err, if_instr, MemRead} !== {1'b1, 1'b0, 32'h00500093, 1'b0}) begin
            errors++;
            $display("FAIL fetch_resp: rdy=%b err=%b instr=%h rd=%b want 1 0 00500093 0", if_ready, if_err, if_instr, MemRead);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL fetch_single_pulse: rdy=%b want 0", if_ready);
        end
    endtask

    task automatic test_store_load();
        int lat; logic err; logic [31:0] rd; int w0;
        w0 = wr_pulses;
        run_ls(1'b1, 32'h100, 3'b010, 32'hDEADBEEF, lat, err, rd);
        checks++;
        if (lat != 2 || err !== 1'b0 || wr_pulses - w0 != 1) begin
            errors++; $display("FAIL sw_0x100: lat=%0d err=%b writes=%0d want 2 0 1", lat, err, wr_pulses - w0);
        end
        run_ls(1'b0, 32'h103, 3'b000, 32'h0, lat, err, rd);
        checks++;
        if (lat != 2 || err !== 1'b0 || rd !== 32'hFFFFFFDE) begin
            errors++; $display("FAIL lb_0x103: lat=%0d err=%b data=%h want 2 0 ffffffde", lat, err, rd);
        end
        run_ls(1'b0, 32'h103, 3'b100, 32'h0, lat, err, rd);
        checks++;
        if (lat != 2 || err !== 1'b0 || rd !== 32'h000000DE) begin
            errors++; $display("FAIL lbu_0x103: lat=%0d err=%b data=%h want 2 0 000000de", lat, err, rd);
        end
        run_ls(1'b0, 32'h102, 3'b001, 32'h0, lat, err, rd);
        checks++;
        if (lat != 2 || err !== 1'b0 || rd !== 32'hFFFFDEAD) begin
            errors++; $display("FAIL lh_0x102: lat=%0d err=%b data=%h want 2 0 ffffdead", lat, err, rd);
        end
    endtask

    task automatic test_arbitration();
        int ls_lat = -1; int if_lat = -1;
        logic [31:0] ls_d = '0; logic [31:0] if_d = '0;
        logic [31:0] first_addr = '0;
        put_word(12'h200, 32'hCAFEF00D);
        put_word(12'h008, 32'h11223344);
        both_hi = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_funct3 = 3'b010;
        if_req = 1'b1; if_addr = 32'h8;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) first_addr = mem_addr;
            if (ls_ready) begin
                ls_lat = (ls_lat == -1) ? k : -2; ls_d = ls_rdata; ls_req = 1'b0;
            end
            if (if_ready) begin
                if_lat = (if_lat == -1) ? k : -2; if_d = if_instr; if_req = 1'b0;
            end
        end
        checks++;
        if (first_addr !== 32'h200) begin
            errors++; $display("FAIL arb_priority: first addr=%h want 00000200", first_addr);
        end
        checks++;
        if (ls_lat != 2 || ls_d !== 32'hCAFEF00D) begin
            errors++; $display("FAIL arb_ls: lat=%0d data=%h want 2 cafef00d", ls_lat, ls_d);
        end
        checks++;
        if (if_lat != 5 || if_d !== 32'h11223344) begin
            errors++; $display("FAIL arb_if: lat=%0d data=%h want 5 11223344", if_lat, if_d);
        end
        checks++;
        if (both_hi !== 1'b0) begin
            errors++; $display("FAIL rd_wr_exclusive: both high seen=%b want 0", both_hi);
        end
    endtask

    task automatic test_illegal();
        // {is_fetch, we, funct3, addr, expect_err}
        logic        fe [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        we [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [8] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b010, 3'b010, 3'b100, 3'b010};
        logic [31:0] ad [8] = '{32'h101, 32'h102, 32'h6, 32'h0, 32'hFFC, 32'hFFE, 32'h0, 32'hFFFFFFFE};
        logic        ex [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        put_word(12'hFFC, 32'h0BADF00D);
        for (int i = 0; i < 8; i++) begin
            int lat; logic err; logic [31:0] rd; int r0; int w0; int mem_ops;
            r0 = rd_pulses; w0 = wr_pulses;
            if (fe[i]) run_if(ad[i], lat, err, rd);
            else       run_ls(we[i], ad[i], f3[i], 32'h55AA55AA, lat, err, rd);
            mem_ops = (rd_pulses - r0) + (wr_pulses - w0);
            checks++;
            if (ex[i]) begin
                if (lat != 1 || err !== 1'b1 || mem_ops != 0) begin
                    errors++;
                    $display("FAIL illegal_%0d: lat=%0d err=%b mem_ops=%0d want 1 1 0", i, lat, err, mem_ops);
                end
            end else begin
                if (lat != 2 || err !== 1'b0 || mem_ops != 1 || rd !== 32'h0BADF00D) begin
                    errors++;
                    $display("FAIL legal_%0d: lat=%0d err=%b mem_ops=%0d data=%h want 2 0 1 0badf00d", i, lat, err, mem_ops, rd);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic err; logic [31:0] rd; int w0; logic seen_ready;
        logic [9:0] outs;
        put_word(12'h300, 32'hA5A5A5A5);
        w0 = wr_pulses;
        seen_ready = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_funct3 = 3'b010; ls_wdata = 32'h12345678;
        tick();
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++; $display("FAIL abort_in_access: MemWrite=%b want 1", MemWrite);
        end
        rst_n = 1'b0;
        #1;
        outs = {MemRead, MemWrite, if_ready, if_err, ls_ready, ls_err, mem_funct3, |mem_addr};
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL abort_outputs: got %b want 0", outs);
        end
        ls_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ls_ready) seen_ready = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ls_ready) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready !== 1'b0 || wr_pulses != w0) begin
            errors++; $display("FAIL abort_no_effect: ready_seen=%b writes=%0d want 0 0", seen_ready, wr_pulses - w0);
        end
        run_ls(1'b0, 32'h300, 3'b010, 32'h0, lat, err, rd);
        checks++;
        if (lat != 2 || err !== 1'b0 || rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL abort_reload: lat=%0d err=%b data=%h want 2 0 a5a5a5a5", lat, err, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_illegal();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the unified byte-addressable data/instruction memory.
- Arbitrates the memory's single port between the instruction-fetch requester and the load/store requester.
- Sequences each access through a small FSM that matches the memory's one-cycle registered read latency.
- Rejects misaligned, illegal-funct3 and out-of-range accesses before they reach memory.

Parameters:
- MEM_BYTES, 4096, size of memory in bytes; the legal address range is 0..MEM_BYTES-1.
- FETCH_FUNCT3, 3'b010, funct3 presented to memory for instruction fetches.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  32  fetch byte address
- if_ready  out  1  one-cycle completion pulse for a fetch
- if_err  out  1  valid with if_ready; the fetch was rejected
- if_instr  out  32  fetched word; valid while if_ready=1 and if_err=0
- ls_req  in  1  load/store request; held high until ls_ready
- ls_we  in  1  1=store, 0=load
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data; lanes right-justified
- ls_funct3  in  3  RISC-V load/store funct3
- ls_ready  out  1  one-cycle completion pulse for a load/store
- ls_err  out  1  valid with ls_ready; the access was rejected
- ls_rdata  out  32  load result; valid while ls_ready=1 and ls_err=0
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_funct3  out  3  memory access size/sign
- mem_rdata  in  32  memory registered read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP, ERR. Every output is registered except if_instr and ls_rdata, which pass mem_rdata through.
- Reset (async, rst_n=0): state=IDLE. All outputs are 0, including MemRead and MemWrite. Reset asserted during ACCESS aborts the access immediately; no write may occur on any edge while rst_n=0.
- IDLE: if ls_req=1, grant goes to load/store. Otherwise, if if_req=1, grant goes to fetch. Load/store has fixed priority. The grant, addr, wdata, funct3 and we are latched into internal registers.
- Legality check on the granted request:
  - Loads: funct3 must be one of 000, 001, 010, 100, 101.
  - Stores: funct3 must be one of 000, 001, 010.
  - Halfword accesses need addr[0]=0. Word accesses and fetches need addr[1:0]=0.
  - The last byte (addr + size - 1) must be < MEM_BYTES.
  - Fetch uses FETCH_FUNCT3 and size 4.
- Transitions out of IDLE: if the granted request is legal, go to ACCESS; if illegal, go to ERR.
- ACCESS, one cycle:
  - MemRead = ~we or fetch; MemWrite = we.
  - mem_addr, mem_wdata and mem_funct3 are driven from the latched values.
  - MemRead and MemWrite are never both 1.
  - Next state: RESP.
- RESP, one cycle:
  - MemRead and MemWrite return to 0.
  - The granted requester's ready=1 and err=0. For a load or fetch, mem_rdata (already formatted by memory) is forwarded.
  - Next state: IDLE.
- ERR, one cycle: the granted requester's ready=1 and err=1. Next state: IDLE. Memory is never touched.
- Latency: a legal request sampled in IDLE at cycle N gets ready in cycle N+2; an illegal one gets ready in cycle N+1.
- Requesters must deassert req in the cycle after ready. A req still high in IDLE is treated as a new request.
- Simultaneous if_req and ls_req: load/store is served first, and the fetch is served in the next IDLE in which ls_req=0.
- mem_wdata is always the full 32-bit ls_wdata; byte-lane selection happens in memory via funct3.
- Address wrap-around: an address whose last byte falls outside the legal range is illegal and never wraps. For example, addr=0xFFFFFFFE with a word access → err.
- Requester inputs are ignored outside IDLE; changes during ACCESS or RESP have no effect.

Decomposition:
- Shared package femto_mem_pkg holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU and F3_SB/SH/SW;
  - the arb_state_t enum (IDLE, ACCESS, RESP, ERR);
  - a size-from-funct3 function.
- One combinational sub-module, mem_access_check, takes addr, funct3, we, is_fetch and MEM_BYTES and outputs legal. It is reused by future MMIO decode.

Test Plan:
- Fetch from 0x00000004 with memory word there = 0x00500093. Required: MemRead=1 in cycle N+1 with mem_funct3=010; if_ready=1, if_err=0 and if_instr=0x00500093 in cycle N+2.
- Store SW 0xDEADBEEF @0x100, then LB @0x103. Required: store ready at N+2 with one MemWrite pulse; the load returns ls_rdata=0xFFFFFFDE, and LBU at 0x103 returns 0x000000DE.
- if_req and ls_req (LW @0x200) rise in the same cycle. Required: ls_ready is asserted at N+2; if_ready follows at N+5 (new accept in IDLE at N+3); MemRead and MemWrite are never both high.
- Misaligned and illegal requests: LH @0x101, SW @0x102, fetch @0x006, load funct3=011, LW @0xFFC with MEM_BYTES=4096 (legal), LW @0xFFE (illegal). Required: each illegal case gets ready+err=1 at N+1 with no MemRead/MemWrite; the legal case completes normally.
- rst_n pulled low during ACCESS of SW @0x300 0x12345678. Required: outputs go to 0 immediately and the state is IDLE; a subsequent LW @0x300 returns the pre-store value, and no ready pulse is issued for the aborted request.
